// File: rtl/pe_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pe_step_ctrl
//  Purpose  : Sequences one ESN time step on a single pe: spaced neuron issue,
//             x write-back, readout-accumulator enables and final y_valid.
//  Option   : PE_CTRL_ABORT_EN adds an abort input that flushes a running step.
//  Revision : 1.0
// ============================================================================
module pe_step_ctrl #(
    parameter int NUM_NRN = 32,
    parameter int AW      = 5,
    parameter int PE_LAT  = 12,
    parameter int X_LAT   = 10,
    parameter int ADD_LAT = 3
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
`ifdef PE_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] nrn_addr,
    output logic          nrn_vld,
    output logic          x_we,
    output logic [AW-1:0] x_waddr,
    output logic          EN_y_sum_in_n,
    output logic          EN_input_Woutb,
    output logic          EN_sum2_n,
    output logic          EN_y_o_n,
    output logic          y_valid
);

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(NUM_NRN - 1);
    localparam int            c_ACC_TAP   = PE_LAT + ADD_LAT;
    localparam int            c_WB_TAP    = PE_LAT + ADD_LAT - 1;
    localparam int            c_RES_TAP   = PE_LAT + 2 * ADD_LAT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [PE_LAT-2:0]    r_vld_pipe;
    logic [c_ACC_TAP-1:0] r_first_pipe;
    logic [c_RES_TAP-1:0] r_last_pipe;

    logic [PE_LAT-1:0]    w_vld_tap;
    logic [c_ACC_TAP:0]   w_first_tap;
    logic [c_RES_TAP:0]   w_last_tap;
    logic                 w_first_now;
    logic                 w_last_now;
    logic                 w_flush;

    // Tap k of each vector is the corresponding issue token delayed k cycles.
    assign w_first_now = nrn_vld && (nrn_addr == '0);
    assign w_last_now  = nrn_vld && (nrn_addr == c_LAST_ADDR);
    assign w_vld_tap   = {r_vld_pipe, nrn_vld};
    assign w_first_tap = {r_first_pipe, w_first_now};
    assign w_last_tap  = {r_last_pipe, w_last_now};

`ifdef PE_CTRL_ABORT_EN
    assign w_flush = abort && busy;
`else
    assign w_flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_vld_pipe     <= '0;
            r_first_pipe   <= '0;
            r_last_pipe    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            nrn_addr       <= '0;
            nrn_vld        <= 1'b0;
            x_we           <= 1'b0;
            EN_y_sum_in_n  <= 1'b1;
            EN_input_Woutb <= 1'b0;
            EN_sum2_n      <= 1'b1;
            EN_y_o_n       <= 1'b1;
            y_valid        <= 1'b0;
        end else if (w_flush) begin
            r_state        <= S_IDLE;
            r_vld_pipe     <= '0;
            r_first_pipe   <= '0;
            r_last_pipe    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            nrn_addr       <= '0;
            nrn_vld        <= 1'b0;
            x_we           <= 1'b0;
            EN_y_sum_in_n  <= 1'b1;
            EN_input_Woutb <= 1'b0;
            EN_sum2_n      <= 1'b1;
            EN_y_o_n       <= 1'b1;
            y_valid        <= 1'b0;
        end else begin
            r_vld_pipe     <= w_vld_tap[PE_LAT-2:0];
            r_first_pipe   <= w_first_tap[c_ACC_TAP-1:0];
            r_last_pipe    <= w_last_tap[c_RES_TAP-1:0];
            x_we           <= w_vld_tap[X_LAT-1];
            EN_y_sum_in_n  <= ~(w_vld_tap[PE_LAT-1] | w_last_tap[c_WB_TAP]);
            EN_input_Woutb <= w_last_tap[c_WB_TAP];
            y_valid        <= w_last_tap[c_RES_TAP];
            done           <= w_last_tap[c_RES_TAP];
            EN_y_o_n       <= ~w_last_tap[c_RES_TAP];
            // Feedback stays off until every ring slot has seen one cleared pass.
            if (w_first_tap[c_ACC_TAP]) begin
                EN_sum2_n <= 1'b0;
            end else if (y_valid) begin
                EN_sum2_n <= 1'b1;
            end
            nrn_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_ISSUE;
                        busy     <= 1'b1;
                        nrn_vld  <= 1'b1;
                        nrn_addr <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_last_now) begin
                        r_state <= S_DRAIN;
                    end else if (w_vld_tap[ADD_LAT-1]) begin
                        nrn_vld  <= 1'b1;
                        nrn_addr <= nrn_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (y_valid) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        if (X_LAT == 1) begin : g_xaddr_direct
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    x_waddr <= '0;
                end else if (w_flush) begin
                    x_waddr <= '0;
                end else begin
                    x_waddr <= nrn_addr;
                end
            end
        end else begin : g_xaddr_pipe
            logic [AW-1:0] r_addr_pipe [X_LAT-1];
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int i = 0; i < X_LAT - 1; i++) r_addr_pipe[i] <= '0;
                    x_waddr <= '0;
                end else if (w_flush) begin
                    for (int i = 0; i < X_LAT - 1; i++) r_addr_pipe[i] <= '0;
                    x_waddr <= '0;
                end else begin
                    r_addr_pipe[0] <= nrn_addr;
                    for (int i = 1; i < X_LAT - 1; i++) r_addr_pipe[i] <= r_addr_pipe[i-1];
                    x_waddr <= r_addr_pipe[X_LAT-2];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pe_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_step_ctrl
//  Purpose  : Randomized bench for pe_step_ctrl (NUM_NRN=4 and NUM_NRN=1 builds)
//             against a cycle-arithmetic reference model.
//  Revision : 1.0
// ============================================================================
module tb_pe_step_ctrl;

    localparam int c_AW  = 5;
    localparam int c_PE  = 12;
    localparam int c_X   = 10;
    localparam int c_ADD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic [1:0] start;
    logic       abort;

    logic [1:0]      busy, done, nrn_vld, x_we, en_ysum_n, en_wb, en_s2_n, en_yo_n, y_valid;
    logic [c_AW-1:0] nrn_addr [2];
    logic [c_AW-1:0] x_waddr  [2];
    logic [18:0]     obs      [2];

    int checks   = 0;
    int failures = 0;

    pe_step_ctrl #(.NUM_NRN(4), .AW(c_AW), .PE_LAT(c_PE), .X_LAT(c_X), .ADD_LAT(c_ADD)) u_dut0 (
        .clk(clk), .nrst(nrst), .start(start[0]),
`ifdef PE_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy[0]), .done(done[0]), .nrn_addr(nrn_addr[0]), .nrn_vld(nrn_vld[0]),
        .x_we(x_we[0]), .x_waddr(x_waddr[0]), .EN_y_sum_in_n(en_ysum_n[0]),
        .EN_input_Woutb(en_wb[0]), .EN_sum2_n(en_s2_n[0]), .EN_y_o_n(en_yo_n[0]),
        .y_valid(y_valid[0])
    );

    pe_step_ctrl #(.NUM_NRN(1), .AW(c_AW), .PE_LAT(c_PE), .X_LAT(c_X), .ADD_LAT(c_ADD)) u_dut1 (
        .clk(clk), .nrst(nrst), .start(start[1]),
`ifdef PE_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy[1]), .done(done[1]), .nrn_addr(nrn_addr[1]), .nrn_vld(nrn_vld[1]),
        .x_we(x_we[1]), .x_waddr(x_waddr[1]), .EN_y_sum_in_n(en_ysum_n[1]),
        .EN_input_Woutb(en_wb[1]), .EN_sum2_n(en_s2_n[1]), .EN_y_o_n(en_yo_n[1]),
        .y_valid(y_valid[1])
    );

    assign obs[0] = {busy[0], done[0], nrn_vld[0], nrn_addr[0], x_we[0], x_waddr[0],
                     en_ysum_n[0], en_wb[0], en_s2_n[0], en_yo_n[0], y_valid[0]};
    assign obs[1] = {busy[1], done[1], nrn_vld[1], nrn_addr[1], x_we[1], x_waddr[1],
                     en_ysum_n[1], en_wb[1], en_s2_n[1], en_yo_n[1], y_valid[1]};

    // Reference model: per instance, whether a step runs and its T0 cycle.
    int cyc = 0;
    bit m_act  [2];
    int m_t0   [2];
    int m_addr [2];

    function automatic int nrn_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int res_rel(input int n);
        return c_PE + n * c_ADD + 1 + c_ADD;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!nrst) begin
                m_act[i]  <= 1'b0;
                m_addr[i] <= 0;
            end else if (m_act[i] && abort) begin
                m_act[i]  <= 1'b0;
                m_addr[i] <= 0;
            end else if (m_act[i] && (cyc - m_t0[i]) == res_rel(nrn_of(i))) begin
                m_act[i]  <= 1'b0;
                m_addr[i] <= nrn_of(i) - 1;
            end else if (!m_act[i] && start[i]) begin
                m_act[i] <= 1'b1;
                m_t0[i]  <= cyc + 1;
            end
        end
        cyc <= cyc + 1;
    end

    function automatic logic [18:0] exp_vec(input int i, input int c);
        int  n, rel, k, a, xa, r;
        bit  bsy, vld, xwe, term, wb, res, s2n;
        n = nrn_of(i);
        r = res_rel(n);
        rel = c - m_t0[i];
        a = m_addr[i];
        xa = 0;
        bsy = 0; vld = 0; xwe = 0; term = 0; wb = 0; res = 0; s2n = 1;
        if (m_act[i] && rel >= 0) begin
            bsy  = (rel <= r);
            vld  = (rel % c_ADD == 0) && (rel / c_ADD < n);
            a    = (rel / c_ADD < n) ? rel / c_ADD : n - 1;
            k    = rel - c_X;
            xwe  = (k >= 0) && (k % c_ADD == 0) && (k / c_ADD < n);
            xa   = xwe ? k / c_ADD : 0;
            k    = rel - c_PE;
            term = (k >= 0) && (k % c_ADD == 0) && (k / c_ADD < n);
            wb   = (rel == c_PE + n * c_ADD);
            res  = (rel == r);
            s2n  = !(rel >= c_PE + c_ADD + 1 && rel <= r);
        end
        return {bsy, res, vld, c_AW'(a), xwe, c_AW'(xa), !(term || wb), wb, s2n, !res, res};
    endfunction

    function automatic logic [18:0] mask_of(input logic [18:0] e);
        return e[10] ? '1 : ~19'h003E0;
    endfunction

    task automatic test_reset();
        logic [18:0] e;
        nrst = 1'b0; start = 2'b00; abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                e = exp_vec(i, cyc);
                checks++;
                if (obs[i] !== e) begin
                    failures++;
                    $display("FAIL reset inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i], e);
                end
            end
        end
        nrst = 1'b1;
    endtask

    task automatic test_nominal();
        logic [18:0] e;
        int halves, pulses;
        halves = 0; pulses = 0;
        @(negedge clk);
        start = 2'b11;
        for (int t = 0; t < 36; t++) begin
            @(negedge clk);
            start = 2'b00;
            if (!en_ysum_n[0]) halves += en_wb[0] ? 2 : 1;
            if (y_valid[0]) pulses++;
            for (int i = 0; i < 2; i++) begin
                e = exp_vec(i, cyc);
                checks++;
                if ((obs[i] & mask_of(e)) !== e) begin
                    failures++;
                    $display("FAIL nominal inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i] & mask_of(e), e);
                end
            end
        end
        // Woutb=1.0 plus four 0.5 terms: y_o must be 3.0, i.e. six halves.
        checks++;
        if (halves !== 6) begin
            failures++;
            $display("FAIL arith_sum got=%0d halves exp=6", halves);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL y_valid_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_start_held();
        logic [18:0] e;
        start = 2'b11;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                e = exp_vec(i, cyc);
                checks++;
                if ((obs[i] & mask_of(e)) !== e) begin
                    failures++;
                    $display("FAIL start_held inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i] & mask_of(e), e);
                end
            end
            if (t == 44) start = 2'b00;
        end
    endtask

    task automatic test_random();
        logic [18:0] e;
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                e = exp_vec(i, cyc);
                checks++;
                if ((obs[i] & mask_of(e)) !== e) begin
                    failures++;
                    $display("FAIL random inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i] & mask_of(e), e);
                end
            end
            start[0] = ($urandom_range(0, 7) == 0);
            start[1] = ($urandom_range(0, 4) == 0);
        end
        start = 2'b00;
    endtask

    task automatic test_reset_midstep();
        logic [18:0] e;
        int hit;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            start = 2'b11;
            hit = $urandom_range(2, 34);
            for (int t = 0; t < 80; t++) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    e = exp_vec(i, cyc);
                    checks++;
                    if ((obs[i] & mask_of(e)) !== e) begin
                        failures++;
                        $display("FAIL reset_mid inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i] & mask_of(e), e);
                    end
                end
                start = (t == hit + 4) ? 2'b11 : 2'b00;
                nrst  = !(t == hit || t == hit + 1);
            end
        end
        nrst = 1'b1;
        start = 2'b00;
    endtask

`ifdef PE_CTRL_ABORT_EN
    task automatic test_abort();
        logic [18:0] e;
        int hit;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            start = 2'b11;
            hit = $urandom_range(1, 40);
            for (int t = 0; t < 80; t++) begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    e = exp_vec(i, cyc);
                    checks++;
                    if ((obs[i] & mask_of(e)) !== e) begin
                        failures++;
                        $display("FAIL abort inst%0d cyc=%0d got=%h exp=%h", i, cyc, obs[i] & mask_of(e), e);
                    end
                end
                abort = (t == hit);
                start = (t == hit || t == hit + 3) ? 2'b11 : 2'b00;
            end
        end
        abort = 1'b0;
        start = 2'b00;
    endtask
`endif

    initial begin
        nrst  = 1'b0;
        start = 2'b00;
        abort = 1'b0;
        test_reset();
        test_nominal();
        test_start_held();
        test_random();
        test_reset_midstep();
`ifdef PE_CTRL_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
